// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline boundary bundle: decode-slot fields and hazard controls in,
// registered EX-stage copies and front-end write enables out.
interface id_ex_stage_if #(
  parameter int unsigned CountWidth = 16
);

  // Decode slot (IF/ID register contents)
  logic                  IF_IDvalid;
  logic [4:0]            IF_IDrs1;
  logic [4:0]            IF_IDrs2;
  logic [4:0]            IF_IDrd;
  logic                  IF_IDuseRs1;
  logic                  IF_IDuseRs2;
  logic [31:0]           IF_IDpc;
  logic [31:0]           IF_IDreadData1;
  logic [31:0]           IF_IDreadData2;
  logic [31:0]           IF_IDimm;
  logic                  IF_IDregWrite;
  logic                  IF_IDmemRead;
  logic                  IF_IDmemWrite;
  logic                  IF_IDmemToReg;
  logic                  IF_IDaluSrc;
  logic [3:0]            IF_IDaluOp;

  // Pipeline control
  logic                  flush;
  logic                  extStall;

  // EX-stage register copies
  logic                  ID_EXvalid;
  logic [4:0]            ID_EXrs1;
  logic [4:0]            ID_EXrs2;
  logic [4:0]            ID_EXrd;
  logic [31:0]           ID_EXpc;
  logic [31:0]           ID_EXreadData1;
  logic [31:0]           ID_EXreadData2;
  logic [31:0]           ID_EXimm;
  logic                  ID_EXregWrite;
  logic                  ID_EXmemRead;
  logic                  ID_EXmemWrite;
  logic                  ID_EXmemToReg;
  logic                  ID_EXaluSrc;
  logic [3:0]            ID_EXaluOp;

  // Front-end enables and bubble statistics
  logic                  PCWrite;
  logic                  IF_IDwrite;
  logic [CountWidth-1:0] stallCount;

  // Decode side: drives the slot and hazard controls, observes the stage.
  modport master (
    output IF_IDvalid, IF_IDrs1, IF_IDrs2, IF_IDrd, IF_IDuseRs1, IF_IDuseRs2,
    output IF_IDpc, IF_IDreadData1, IF_IDreadData2, IF_IDimm,
    output IF_IDregWrite, IF_IDmemRead, IF_IDmemWrite, IF_IDmemToReg, IF_IDaluSrc, IF_IDaluOp,
    output flush, extStall,
    input  ID_EXvalid, ID_EXrs1, ID_EXrs2, ID_EXrd, ID_EXpc,
    input  ID_EXreadData1, ID_EXreadData2, ID_EXimm,
    input  ID_EXregWrite, ID_EXmemRead, ID_EXmemWrite, ID_EXmemToReg, ID_EXaluSrc, ID_EXaluOp,
    input  PCWrite, IF_IDwrite, stallCount
  );

  // Stage side.
  modport slave (
    input  IF_IDvalid, IF_IDrs1, IF_IDrs2, IF_IDrd, IF_IDuseRs1, IF_IDuseRs2,
    input  IF_IDpc, IF_IDreadData1, IF_IDreadData2, IF_IDimm,
    input  IF_IDregWrite, IF_IDmemRead, IF_IDmemWrite, IF_IDmemToReg, IF_IDaluSrc, IF_IDaluOp,
    input  flush, extStall,
    output ID_EXvalid, ID_EXrs1, ID_EXrs2, ID_EXrd, ID_EXpc,
    output ID_EXreadData1, ID_EXreadData2, ID_EXimm,
    output ID_EXregWrite, ID_EXmemRead, ID_EXmemWrite, ID_EXmemToReg, ID_EXaluSrc, ID_EXaluOp,
    output PCWrite, IF_IDwrite, stallCount
  );

endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Per-edge priority: reset > external hold > flush bubble > load-use bubble > capture.
module id_ex_stage #(
  parameter int unsigned CountWidth = 16
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
  } ex_regs_t;

  ex_regs_t              ex_q, ex_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  load_use;
  logic                  rs1_hit, rs2_hit;
  logic                  slot_valid;

  // Load-use hazard: a valid load in EX whose non-x0 target is read by the decode slot.
  always_comb begin
    rs1_hit  = bus.IF_IDuseRs1 && (bus.IF_IDrs1 == ex_q.rd);
    rs2_hit  = bus.IF_IDuseRs2 && (bus.IF_IDrs2 == ex_q.rd);
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.IF_IDvalid &&
               (rs1_hit || rs2_hit);
  end

  // Front-end enables: advance on capture or flush bubble, never on hold, load-use or reset.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IF_IDwrite = 1'b0;
    if (rst_n && !bus.extStall && (bus.flush || !load_use)) begin
      bus.PCWrite    = 1'b1;
      bus.IF_IDwrite = 1'b1;
    end
  end

  // Next-state selection for the EX register set and bubble counter.
  always_comb begin
    slot_valid = bus.IF_IDvalid;
    ex_d       = ex_q;
    count_d    = count_q;
    if (bus.extStall) begin
      ex_d    = ex_q;
      count_d = count_q;
    end else if (bus.flush) begin
      // Flush outranks load-use: the dependent instruction is dead anyway, so no count.
      ex_d = '0;
    end else if (load_use) begin
      ex_d = '0;
      if (count_q != {CountWidth{1'b1}}) begin
        count_d = count_q + 1'b1;
      end
    end else begin
      ex_d.valid      = slot_valid;
      ex_d.rs1        = slot_valid ? bus.IF_IDrs1 : 5'd0;
      ex_d.rs2        = slot_valid ? bus.IF_IDrs2 : 5'd0;
      ex_d.rd         = slot_valid ? bus.IF_IDrd  : 5'd0;
      ex_d.pc         = bus.IF_IDpc;
      ex_d.read_data1 = bus.IF_IDreadData1;
      ex_d.read_data2 = bus.IF_IDreadData2;
      ex_d.imm        = bus.IF_IDimm;
      ex_d.reg_write  = slot_valid & bus.IF_IDregWrite;
      ex_d.mem_read   = slot_valid & bus.IF_IDmemRead;
      ex_d.mem_write  = slot_valid & bus.IF_IDmemWrite;
      ex_d.mem_to_reg = slot_valid & bus.IF_IDmemToReg;
      ex_d.alu_src    = slot_valid & bus.IF_IDaluSrc;
      ex_d.alu_op     = slot_valid ? bus.IF_IDaluOp : 4'd0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      count_q <= '0;
    end else begin
      ex_q    <= ex_d;
      count_q <= count_d;
    end
  end

  assign bus.ID_EXvalid     = ex_q.valid;
  assign bus.ID_EXrs1       = ex_q.rs1;
  assign bus.ID_EXrs2       = ex_q.rs2;
  assign bus.ID_EXrd        = ex_q.rd;
  assign bus.ID_EXpc        = ex_q.pc;
  assign bus.ID_EXreadData1 = ex_q.read_data1;
  assign bus.ID_EXreadData2 = ex_q.read_data2;
  assign bus.ID_EXimm       = ex_q.imm;
  assign bus.ID_EXregWrite  = ex_q.reg_write;
  assign bus.ID_EXmemRead   = ex_q.mem_read;
  assign bus.ID_EXmemWrite  = ex_q.mem_write;
  assign bus.ID_EXmemToReg  = ex_q.mem_to_reg;
  assign bus.ID_EXaluSrc    = ex_q.alu_src;
  assign bus.ID_EXaluOp     = ex_q.alu_op;
  assign bus.stallCount     = count_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 IF_IDvalid  in  1  decode slot holds a real instruction.
REQ-005 IF_IDrs1, IF_IDrs2, IF_IDrd  in  5 each  decoded register indices.
REQ-006 IF_IDuseRs1, IF_IDuseRs2  in  1 each  instruction actually reads rs1/rs2.
REQ-007 IF_IDpc, IF_IDreadData1, IF_IDreadData2, IF_IDimm  in  32 each  PC, register-file operands, immediate.
REQ-008 IF_IDregWrite, IF_IDmemRead, IF_IDmemWrite, IF_IDmemToReg, IF_IDaluSrc  in  1 each  decoded controls.
REQ-009 IF_IDaluOp  in  4  decoded ALU operation.
REQ-010 flush  in  1  taken branch/jump resolved in EX; kill decode slot.
REQ-011 extStall  in  1  memory-side stall; freeze this stage.
REQ-012 ID_EXvalid, ID_EXrs1, ID_EXrs2, ID_EXrd, ID_EXpc, ID_EXreadData1, ID_EXreadData2, ID_EXimm, ID_EXregWrite, ID_EXmemRead, ID_EXmemWrite, ID_EXmemToReg, ID_EXaluSrc, ID_EXaluOp  out  widths as inputs  registered EX-stage copies (rs1/rs2 feed forwarding unit).
REQ-013 PCWrite  out  1  PC may advance this cycle.
REQ-014 IF_IDwrite  out  1  IF/ID register may load this cycle.
REQ-015 stallCount  out  16  saturating count of load-use bubbles inserted.

Function
REQ-016 loadUse (combinational) SHALL = ID_EXvalid & ID_EXmemRead & (ID_EXrd!=0) & IF_IDvalid & ((IF_IDuseRs1 & IF_IDrs1==ID_EXrd) | (IF_IDuseRs2 & IF_IDrs2==ID_EXrd)).
REQ-017 Per-edge action priority SHALL be: rst_n low > extStall > flush > loadUse > capture.
REQ-018 Hold (extStall=1): all ID_EX registers and stallCount unchanged; PCWrite=0, IF_IDwrite=0; flush ignored this cycle (source holds it until extStall drops).
REQ-019 Bubble (flush=1, or loadUse=1): next-cycle ID_EXvalid=0, all control outputs 0, ID_EXaluOp=0, rs1/rs2/rd=0, pc/data/imm=0.
REQ-020 On flush bubble PCWrite=1, IF_IDwrite=1 (IF/ID kill handled upstream); stallCount unchanged.
REQ-021 On loadUse bubble PCWrite=0, IF_IDwrite=0 (decode instruction held one cycle); stallCount +1, saturating at 16'hFFFF.
REQ-022 Capture: all ID_EX fields load from IF_ID inputs in one cycle; control bits and ID_EXvalid AND-gated with IF_IDvalid (invalid slot => regWrite/memRead/memWrite/memToReg=0, indices forced 0); PCWrite=1, IF_IDwrite=1.
REQ-023 Latency: decode-to-EX exactly 1 cycle absent hold/bubble; load-use dependency costs exactly 1 bubble, after which loadUse SHALL be 0 (ID_EXvalid=0) and the held instruction is captured.
REQ-024 ID_EXrd=0 SHALL never trigger loadUse; loads to x0 cause no stall.
REQ-025 Back-to-back loads with chained dependency SHALL each insert exactly one bubble.
REQ-026 PCWrite, IF_IDwrite SHALL be combinational from current state and inputs; all other outputs registered.

Reset
REQ-027 rst_n=0 at a rising edge SHALL clear all registered outputs to 0 (ID_EXvalid=0, stallCount=0) regardless of extStall/flush.
REQ-028 While rst_n=0, PCWrite=0 and IF_IDwrite=0.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction; first edge after rst_n=1 performs normal capture.

Verification
REQ-030 lw x5 in EX (memRead=1, rd=5), decode add x6,x5,x7 (useRs1=1, rs1=5) -> PCWrite=0, IF_IDwrite=0; next cycle ID_EXvalid=0, stallCount=1; following cycle ID_EXrs1=5 captured.
REQ-031 lw x0 in EX, decode rs1=0 useRs1=1 -> no stall, PCWrite=1, stallCount stays 0.
REQ-032 flush=1 and loadUse=1 same cycle -> bubble, PCWrite=1, IF_IDwrite=1, stallCount unchanged.
REQ-033 extStall=1 for 3 cycles with flush=1 -> ID_EX outputs frozen, PCWrite=0; on extStall=0 with flush still 1 -> bubble.
REQ-034 stallCount preset via 65535 load-use events then one more -> stays 16'hFFFF.
REQ-035 rst_n=0 for one edge during loadUse with IF_IDvalid=1 -> all outputs 0; next edge with rst_n=1 captures IF_ID inputs.
